// File: rtl/spram_arbiter.sv
// Two-port arbiter/sequencer for a 16-bit single-port SPRAM: A is a byte bus, B a word master.
// Define SPRAM_ARB_RR_EN for round-robin contention instead of A-priority with a B starvation guard.
module spram_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [14:0] a_addr,
  input  logic [7:0]  a_din,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [7:0]  a_dout,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [13:0] b_addr,
  input  logic [15:0] b_din,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [15:0] b_dout,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [3:0]  ram_mask,
  output logic        ram_we,
  output logic        ram_cs,
  input  logic [15:0] ram_dout
);

  logic        a_gnt, b_gnt;
  logic        a_rvalid_q, b_rvalid_q;
  logic        lane_q;
  logic [7:0]  a_hold_q;
  logic [15:0] b_hold_q;
  logic [7:0]  a_rdata;
  logic [13:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        contest_a;

`ifdef SPRAM_ARB_RR_EN
  logic last_b_q;

  // On a contested cycle the port that did not win last time goes first.
  assign contest_a = last_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else if (a_gnt || b_gnt) begin
      last_b_q <= b_gnt;
    end
  end
`else
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve;

  assign starve    = (wait_q == WAIT_W'(MAX_WAIT));
  assign contest_a = !starve;

  always_comb begin
    wait_d = '0;
    if (b_req && !b_gnt) begin
      wait_d = starve ? wait_q : wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  always_comb begin
    if (a_req && b_req) begin
      a_gnt = contest_a;
      b_gnt = !contest_a;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  assign a_ack = a_gnt;
  assign b_ack = b_gnt;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_mask = 4'b0000;
    addr_d   = addr_q;
    din_d    = din_q;
    if (a_gnt) begin
      ram_cs   = 1'b1;
      ram_we   = a_we;
      ram_mask = a_addr[0] ? 4'b1100 : 4'b0011;
      addr_d   = a_addr[14:1];
      din_d    = {a_din, a_din};
    end else if (b_gnt) begin
      ram_cs   = 1'b1;
      ram_we   = b_we;
      ram_mask = 4'b1111;
      addr_d   = b_addr;
      din_d    = b_din;
    end
  end

  // Idle cycles replay the last address/data so the SPRAM pins do not toggle.
  assign ram_addr = addr_d;
  assign ram_din  = din_d;

  assign a_rdata  = lane_q ? ram_dout[15:8] : ram_dout[7:0];
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_dout   = a_rvalid_q ? a_rdata  : a_hold_q;
  assign b_dout   = b_rvalid_q ? ram_dout : b_hold_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      lane_q     <= 1'b0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      a_rvalid_q <= a_gnt && !a_we;
      b_rvalid_q <= b_gnt && !b_we;
      if (a_gnt && !a_we) begin
        lane_q <= a_addr[0];
      end
      if (a_rvalid_q) begin
        a_hold_q <= a_rdata;
      end
      if (b_rvalid_q) begin
        b_hold_q <= ram_dout;
      end
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: SPRAM model, byte-level reference model, directed and random traffic.
module tb_spram_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [14:0] a_addr = '0;
  logic [7:0]  a_din = '0;
  logic        a_ack, a_rvalid;
  logic [7:0]  a_dout;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [13:0] b_addr = '0;
  logic [15:0] b_din = '0;
  logic        b_ack, b_rvalid;
  logic [15:0] b_dout;
  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic [3:0]  ram_mask;
  logic        ram_we, ram_cs;
  logic [15:0] ram_dout = '0;

  int checks = 0;
  int failures = 0;

  spram_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_dout(b_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_mask(ram_mask),
    .ram_we(ram_we), .ram_cs(ram_cs), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPRAM primitive: nibble-masked write, registered read one cycle after a read select.
  logic [15:0] spram [0:16383];
  logic [15:0] wword;
  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      wword = spram[ram_addr];
      for (int n = 0; n < 4; n++) begin
        if (ram_mask[n]) wword[n*4 +: 4] = ram_din[n*4 +: 4];
      end
      spram[ram_addr] <= wword;
    end
    if (ram_cs && !ram_we) ram_dout <= spram[ram_addr];
  end

  // Reference model: byte-addressed shadow memory plus the arbitration rules.
  logic [7:0]  shadow [0:32767];
  int          m_wait;
  bit          m_last_b;
  bit          m_pa, m_pb, ga, gb;
  logic [7:0]  m_pa_data, m_ahold;
  logic [15:0] m_pb_data, m_bhold, m_din;
  logic [13:0] m_addr;
  logic        e_we;
  logic [3:0]  e_mask;

  initial begin
    for (int i = 0; i < 16384; i++) spram[i] = '0;
    for (int i = 0; i < 32768; i++) shadow[i] = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_wait = 0; m_last_b = 1'b1; m_pa = 1'b0; m_pb = 1'b0;
      m_ahold = '0; m_bhold = '0; m_addr = '0; m_din = '0;
      check("rst_a_rvalid", 32'(a_rvalid), 0);
      check("rst_b_rvalid", 32'(b_rvalid), 0);
      check("rst_a_dout", 32'(a_dout), 0);
      check("rst_b_dout", 32'(b_dout), 0);
    end else begin
      if (m_pa) m_ahold = m_pa_data;
      if (m_pb) m_bhold = m_pb_data;
      check("a_rvalid", 32'(a_rvalid), 32'(m_pa));
      check("b_rvalid", 32'(b_rvalid), 32'(m_pb));
      check("a_dout", 32'(a_dout), 32'(m_ahold));
      check("b_dout", 32'(b_dout), 32'(m_bhold));
      if (a_req && b_req) begin
`ifdef SPRAM_ARB_RR_EN
        ga = m_last_b;
`else
        ga = (m_wait != MAX_WAIT);
`endif
      end else begin
        ga = a_req;
      end
      gb = b_req && !ga;
      check("a_ack", 32'(a_ack), 32'(ga));
      check("b_ack", 32'(b_ack), 32'(gb));
      check("ram_cs", 32'(ram_cs), 32'(ga || gb));
      e_we = 1'b0; e_mask = 4'h0;
      if (ga) begin
        e_we = a_we; e_mask = a_addr[0] ? 4'hC : 4'h3;
        m_addr = a_addr[14:1]; m_din = {a_din, a_din};
      end else if (gb) begin
        e_we = b_we; e_mask = 4'hF;
        m_addr = b_addr; m_din = b_din;
      end
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("ram_mask", 32'(ram_mask), 32'(e_mask));
      check("ram_addr", 32'(ram_addr), 32'(m_addr));
      check("ram_din", 32'(ram_din), 32'(m_din));
      if (b_req && !gb) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      if (ga || gb) m_last_b = gb;
      m_pa = ga && !a_we;
      m_pa_data = shadow[a_addr];
      m_pb = gb && !b_we;
      m_pb_data = {shadow[{b_addr, 1'b1}], shadow[{b_addr, 1'b0}]};
      if (ga && a_we) shadow[a_addr] = a_din;
      if (gb && b_we) begin
        shadow[{b_addr, 1'b0}] = b_din[7:0];
        shadow[{b_addr, 1'b1}] = b_din[15:8];
      end
    end
  end

  logic [13:0] got_addr;
  logic [15:0] got_din;
  logic [3:0]  got_mask;

  // Issues one access and returns just after the edge following the grant (the rvalid cycle).
  task automatic a_op(input logic we, input logic [14:0] addr, input logic [7:0] din);
    int n = 0;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = we; a_addr = addr; a_din = din;
    @(negedge clk);
    while (!a_ack && n < 20) begin @(negedge clk); n++; end
    check("a_op_ack", 32'(a_ack), 1);
    got_addr = ram_addr; got_din = ram_din; got_mask = ram_mask;
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic b_op(input logic we, input logic [13:0] addr, input logic [15:0] din);
    int n = 0;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = we; b_addr = addr; b_din = din;
    @(negedge clk);
    while (!b_ack && n < 20) begin @(negedge clk); n++; end
    check("b_op_ack", 32'(b_ack), 1);
    got_addr = ram_addr; got_din = ram_din; got_mask = ram_mask;
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_a();
    a_we = 1'($urandom_range(0, 1));
    a_addr = 15'($urandom_range(0, 127));
    a_din = 8'($urandom);
  endtask

  task automatic rand_b();
    b_we = 1'($urandom_range(0, 1));
    b_addr = 14'($urandom_range(0, 63));
    b_din = 16'($urandom);
  endtask

  bit a_seen, b_seen, exp_b;

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_cs", 32'(ram_cs), 0);
    check("idle_acks", 32'({a_ack, b_ack}), 0);
    check("idle_rvalids", 32'({a_rvalid, b_rvalid}), 0);
    check("idle_a_dout", 32'(a_dout), 32'h00);
    check("idle_b_dout", 32'(b_dout), 32'h0000);

    // A byte write then reads of both lanes
    a_op(1'b1, 15'h0003, 8'hA5);
    check("a_wr_addr", 32'(got_addr), 32'h0001);
    check("a_wr_din", 32'(got_din), 32'hA5A5);
    check("a_wr_mask", 32'(got_mask), 32'hC);
    a_op(1'b0, 15'h0003, 8'h00);
    @(negedge clk);
    check("a_rd_hi_rvalid", 32'(a_rvalid), 1);
    check("a_rd_hi_data", 32'(a_dout), 32'hA5);
    a_op(1'b0, 15'h0002, 8'h00);
    @(negedge clk);
    check("a_rd_lo_data", 32'(a_dout), 32'h00);

    // B word write/read and A byte view of it
    b_op(1'b1, 14'h0010, 16'h1234);
    check("b_wr_mask", 32'(got_mask), 32'hF);
    b_op(1'b0, 14'h0010, 16'h0000);
    @(negedge clk);
    check("b_rd_rvalid", 32'(b_rvalid), 1);
    check("b_rd_data", 32'(b_dout), 32'h1234);
    a_op(1'b0, 15'h0021, 8'h00);
    @(negedge clk);
    check("a_view_of_b", 32'(a_dout), 32'h12);

    // Interleaved A then B reads on consecutive cycles
    a_op(1'b1, 15'h0040, 8'h5A);
    b_op(1'b1, 14'h0030, 16'hBEEF);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0040;
    @(negedge clk);
    check("il_a_ack", 32'(a_ack), 1);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0030;
    @(negedge clk);
    check("il_b_ack", 32'(b_ack), 1);
    check("il_a_rvalid", 32'(a_rvalid), 1);
    check("il_a_data", 32'(a_dout), 32'h5A);
    check("il_b_rvalid_early", 32'(b_rvalid), 0);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    check("il_b_rvalid", 32'(b_rvalid), 1);
    check("il_b_data", 32'(b_dout), 32'hBEEF);
    check("il_a_rvalid_gone", 32'(a_rvalid), 0);

    // Continuous contention from a clean reset
    do_reset(2);
    rand_a(); rand_b();
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
`ifdef SPRAM_ARB_RR_EN
      exp_b = (i % 2) == 1;
`else
      exp_b = (i % (MAX_WAIT + 1)) == MAX_WAIT;
`endif
      check("contend_b_ack", 32'(b_ack), 32'(exp_b));
      check("contend_a_ack", 32'(a_ack), 32'(!exp_b));
      a_seen = a_ack; b_seen = b_ack;
      @(posedge clk); #1;
      if (a_seen) rand_a();
      if (b_seen) rand_b();
    end
    a_req = 1'b0; b_req = 1'b0;

    // Random protocol-respecting traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_seen = a_ack; b_seen = b_ack;
      @(posedge clk); #1;
      if (a_req) begin
        if (a_seen) begin
          a_req = ($urandom_range(0, 3) != 0);
          if (a_req) rand_a();
        end else if ($urandom_range(0, 15) == 0) begin
          a_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        a_req = 1'b1; rand_a();
      end
      if (b_req) begin
        if (b_seen) begin
          b_req = ($urandom_range(0, 3) != 0);
          if (b_req) rand_b();
        end else if ($urandom_range(0, 31) == 0) begin
          b_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        b_req = 1'b1; rand_b();
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) @(posedge clk);

    // Reset lands in the cycle after an A read grant
    a_op(1'b1, 15'h0005, 8'h77);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0005;
    @(negedge clk);
    check("mid_rst_ack", 32'(a_ack), 1);
    @(posedge clk); #1;
    a_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_a_rvalid", 32'(a_rvalid), 0);
    check("mid_rst_a_dout", 32'(a_dout), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_a_rvalid", 32'(a_rvalid), 0);
    check("post_rst_a_dout", 32'(a_dout), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
